// File: rtl/t5_sysctl_if.sv
// t5_sysctl_if: per-channel bus strobe/acknowledge/clear bundle with sticky timeout flags
// Ports (signals): xstb request strobe, xack acknowledge, tclr timeout-flag clear pulse, tout sticky timeout flag.
// master drives the requests and reads tout; slave is the controller side.
interface t5_sysctl_if #(parameter int NCH = 2);
  logic [NCH-1:0] xstb, xack, tclr, tout;
  modport master(output xstb, xack, tclr, input tout);
  modport slave(input xstb, xack, tclr, output tout);
endinterface

// File: rtl/t5_sysctl.sv
// t5_sysctl: clock pass-through, reset stretcher and multi-channel stall/enable with acknowledge watchdog
// Ports: sys_clk system clock; sys_rst async active-low reset; sys_ena global enable;
// bus per-channel xstb/xack/tclr in, tout out; sclk core clock; srst core reset (active-high);
// sena core enable.
module t5_sysctl #(
  parameter int NCH    = 2,
  parameter int RSTLEN = 4,
  parameter int TOW    = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        sys_ena,
  t5_sysctl_if.slave  bus,
  output logic        sclk,
  output logic        srst,
  output logic        sena
);
  logic [RSTLEN-1:0] rsh_q, rsh_d;
  logic [TOW-1:0]    cnt_q [NCH];
  logic [TOW-1:0]    cnt_d [NCH];
  logic [NCH-1:0]    tout_q, tout_d, wt, stall;
  assign sclk     = sys_clk;
  assign srst     = rsh_q[RSTLEN-1];
  assign wt       = bus.xstb & ~bus.xack;
  // a channel whose timeout flag is set no longer holds the core
  assign stall    = wt & ~tout_q;
  assign sena     = sys_ena & ~srst & ~|stall;
  assign bus.tout = tout_q;
  always_comb begin
    rsh_d = {rsh_q[RSTLEN-2:0], 1'b0};
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i]  = (!srst && stall[i] && cnt_q[i] != '1) ? cnt_q[i] + TOW'(1) : '0;
      // expiry takes priority over a simultaneous clear
      tout_d[i] = !srst && ((stall[i] && cnt_q[i] == '1) || (tout_q[i] && !bus.tclr[i]));
    end
  end
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      rsh_q  <= '1;
      tout_q <= '0;
      cnt_q  <= '{default: '0};
    end else begin
      rsh_q  <= rsh_d;
      tout_q <= tout_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_t5_sysctl.sv
// tb_t5_sysctl: randomized and directed checks of t5_sysctl against a cycle-level reference model
module tb_t5_sysctl;
  localparam int NCH = 2, RSTLEN = 4, TOW = 4;
  localparam int LIM = (1 << TOW) - 1;
  logic sys_clk = 1'b0, sys_rst, sys_ena, sclk, srst, sena;
  int n_chk = 0, n_fail = 0;
  int rcnt;
  int age [NCH];
  bit tm [NCH];
  t5_sysctl_if #(.NCH(NCH)) bus ();
  t5_sysctl #(.NCH(NCH), .RSTLEN(RSTLEN), .TOW(TOW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .sys_ena(sys_ena), .bus(bus),
    .sclk(sclk), .srst(srst), .sena(sena)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit srst_m();
    return rcnt < RSTLEN;
  endfunction
  function automatic bit sena_m();
    bit s = sys_ena && !srst_m();
    for (int i = 0; i < NCH; i++) if (bus.xstb[i] && !bus.xack[i] && !tm[i]) s = 0;
    return s;
  endfunction
  function automatic logic [NCH-1:0] tout_m();
    logic [NCH-1:0] t;
    for (int i = 0; i < NCH; i++) t[i] = tm[i];
    return t;
  endfunction
  task automatic model_reset();
    rcnt = 0;
    for (int i = 0; i < NCH; i++) begin age[i] = 0; tm[i] = 0; end
  endtask
  task automatic model_edge();
    if (!sys_rst) return;
    if (srst_m()) begin
      for (int i = 0; i < NCH; i++) begin age[i] = 0; tm[i] = 0; end
      rcnt++;
      return;
    end
    for (int i = 0; i < NCH; i++) begin
      bit pend = bus.xstb[i] && !bus.xack[i];
      bit set = 0;
      if (pend && !tm[i]) begin
        if (age[i] == LIM) begin set = 1; age[i] = 0; end
        else age[i]++;
      end else age[i] = 0;
      if (set) tm[i] = 1;
      else if (bus.tclr[i]) tm[i] = 0;
    end
  endtask
  task automatic cyc(input logic [NCH-1:0] stb, ack, clr, input logic ena, input int es, input int et);
    @(negedge sys_clk);
    bus.xstb = stb; bus.xack = ack; bus.tclr = clr; sys_ena = ena;
    #1;
    check("sena", sena, sena_m());
    check("srst", srst, srst_m());
    check("tout", bus.tout, tout_m());
    if (es >= 0) check("sena_dir", sena, es[0]);
    if (et >= 0) check("tout_dir", bus.tout, et[NCH-1:0]);
    @(posedge sys_clk);
    model_edge();
  endtask
  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b0;
    #1;
    model_reset();
    check("rst_srst", srst, 1);
    check("rst_sena", sena, 0);
    check("rst_tout", bus.tout, 0);
    check("rst_sclk_lo", sclk, sys_clk);
    @(posedge sys_clk);
    model_edge();
    #1;
    check("rst_sclk_hi", sclk, 1);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    #1;
    check("rel_srst", srst, 1);
    @(posedge sys_clk);
    model_edge();
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "time limit");
  end
  initial begin
    logic [NCH-1:0] ms0 [7] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00};
    logic [NCH-1:0] ma0 [7] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b10};
    int me [7] = '{0, 0, 0, 0, 0, 1, 1};
    sys_rst = 1'b0; sys_ena = 1'b0;
    bus.xstb = '0; bus.xack = '0; bus.tclr = '0;
    model_reset();
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      @(negedge sys_clk);
      sys_ena = 1'b1;
      #1;
      check("srst_stretch", srst, (k < RSTLEN) ? 1 : 0);
      check("sena_stretch", sena, (k < RSTLEN) ? 0 : 1);
      @(posedge sys_clk);
      model_edge();
    end
    do_reset();
    cyc('0, '0, '0, 1, 0, 0);
    do_reset();
    for (int k = 0; k < 3; k++) cyc('0, '0, '0, 1, 0, 0);
    cyc('0, '0, '0, 1, 1, 0);
    cyc(2'b01, 2'b01, '0, 1, 1, 0);
    cyc('0, '0, '0, 1, 1, 0);
    for (int c = 0; c < 7; c++) cyc(ms0[c], ma0[c], '0, 1, me[c], 0);
    for (int c = 0; c <= 16; c++) cyc(2'b01, '0, '0, 1, c < 16 ? 0 : 1, c < 16 ? 0 : 1);
    cyc(2'b01, '0, 2'b01, 1, 1, 1);
    for (int c = 18; c <= 33; c++) cyc(2'b01, '0, c == 33 ? 2'b01 : 2'b00, 1, 0, 0);
    cyc(2'b01, '0, '0, 1, 1, 1);
    cyc('0, '0, 2'b01, 1, 1, 1);
    cyc('0, '0, '0, 1, 1, 0);
    cyc('0, '0, '0, 0, 0, 0);
    for (int c = 0; c <= 16; c++) cyc(2'b10, '0, '0, 0, 0, c < 16 ? 0 : 2);
    cyc('0, '0, 2'b10, 1, 1, 2);
    cyc('0, '0, '0, 1, 1, 0);
    for (int c = 0; c < 3000; c++) begin
      logic [NCH-1:0] s, a, t;
      for (int i = 0; i < NCH; i++) begin
        s[i] = $urandom_range(0, 3) != 0;
        a[i] = $urandom_range(0, 7) == 0;
        t[i] = $urandom_range(0, 15) == 0;
      end
      if ($urandom_range(0, 299) == 0) do_reset();
      else cyc(s, a, t, $urandom_range(0, 7) != 0, -1, -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/t5_sysctl.md
# t5_sysctl

Parametrised system controller for the t5 core, the next generation of the single-channel system controller. It passes the system clock through and stretches and synchronises the external reset into the core reset. It generates the core pipeline enable from NCH independent bus channels, and adds a per-channel acknowledge watchdog so that a dead slave cannot hang the core. It sits between the board-level clock/reset/enable pins and the core plus its bus interfaces.

## Interface

Parameters:
- NCH, 2: number of bus channels that can stall the core (1..8).
- RSTLEN, 4: reset stretch depth in sys_clk cycles (2..16).
- TOW, 8: watchdog counter width; timeout limit is 2^TOW-1.

Ports:
- sys_clk  input  1  system clock; sole clock domain.
- sys_rst  input  1  system reset; asynchronous assert, active-low.
- sys_ena  input  1  global enable from board/debugger.
- xstb  input  NCH  per-channel request strobe; held high until acknowledged.
- xack  input  NCH  per-channel acknowledge.
- tclr  input  NCH  per-channel timeout-flag clear, 1-cycle pulse.
- sclk  output  1  core clock, equal to sys_clk.
- srst  output  1  core reset, active-high, synchronously deasserted.
- sena  output  1  core enable.
- tout  output  NCH  sticky per-channel timeout flag.

## Operation

Clock:
- sclk is driven directly by sys_clk, with no gating or logic in the path.

Reset stretcher:
- RSTLEN-bit shift register rsh.
- sys_rst low sets all rsh bits to 1 asynchronously.
- When sys_rst is high, each edge shifts in 0: rsh <= {rsh[RSTLEN-2:0],1'b0}.
- srst = rsh[RSTLEN-1].
- Assertion of srst is immediate (asynchronous). Deassertion occurs after exactly RSTLEN rising edges with sys_rst high.

Per-channel wait:
- wait[i] = xstb[i] & ~xack[i].
- xack[i] with xstb[i] low is ignored. This deliberately differs from the XOR rule of the previous controller.

Watchdog (per channel i):
- Counter cnt[i] is TOW bits wide.
- When srst is high: cnt = 0 and tout = 0.
- If wait[i] & ~tout[i]:
  - if cnt[i] == 2^TOW-1, then tout[i] <= 1 and cnt[i] <= 0;
  - otherwise cnt[i] <= cnt[i]+1.
- If ~wait[i] or tout[i]: cnt[i] <= 0.
- tclr[i] clears tout[i] on the next edge. If tclr[i] and a timeout set occur on the same edge, the set wins.
- A tout[i] that is set releases channel i's stall. The core proceeds and software or the bus interface observes the flag.
- After tclr, a still-pending wait restarts counting from 0.

Enable:
- sena = sys_ena & ~srst & ~|(wait & ~tout).
- sena is combinational from xstb, xack and sys_ena, and registered from tout and srst.

## Timing

Reset values (sys_rst low):
- srst = 1
- sena = 0
- tout = 0
- all cnt = 0
- rsh = all ones
- sclk follows sys_clk even during reset.

Reset release:
- sys_rst rises before edge E1. srst falls after edge E_RSTLEN. sena can first be 1 in the following cycle.

Stall and acknowledge:
- Zero latency: xstb high with xack low in cycle k forces sena=0 in cycle k.
- xack high in cycle k gives sena=1 in cycle k. This is a single-cycle acknowledge, so no stall occurs.

Timeout cycle count:
- With wait[i] continuously high from cycle 0, sena is low for cycles 0..2^TOW-1.
- tout[i] is high from cycle 2^TOW, and sena is released in that cycle if no other channel waits.

Channel independence:
- Counters and flags are fully independent per channel; sena is the AND over all channels.

Mid-operation reset:
- sys_rst low at any time immediately forces srst=1 and sena=0.
- Counters and flags clear asynchronously.
- In-flight strobes are not tracked across reset.

## Test plan

- Reset stretch: RSTLEN=4, release sys_rst between edges. srst stays 1 through edges 1-3 and reads 0 after edge 4. Re-asserting sys_rst mid-count sets srst=1 immediately.
- Single-cycle handshake: NCH=2, xstb[0]=xack[0]=1 for one cycle with sys_ena=1. sena stays 1 throughout, and cnt[0] stays 0.
- Multi-channel stall: xstb[0] acked after 3 cycles, xstb[1] acked after 5 cycles, both starting in cycle 0. sena is 0 for cycles 0-4 and 1 in cycle 5. Spurious xack[1] alone does not affect sena.
- Watchdog: TOW=4, xstb[0]=1 with xack never asserted. sena is 0 for cycles 0-15, then tout[0]=1 and sena=1 in cycle 16. tout[1] stays 0.
- Clear/set race: tclr[0] pulsed on the same edge that a second timeout expires leaves tout[0]=1. tclr[0] pulsed with xstb[0] low gives tout[0]=0 next cycle.
- Global enable: sys_ena=0 with no waits gives sena=0. Watchdog counters still advance on a waiting channel.
